// File: rtl/fast9_frame_scheduler.sv
// fast9_frame_scheduler: frame-level sequencer for the FAST-9 datapath.
// Clears both result banks, runs the detect pass (scores -> bank 0), then the
// NMS pass (corner map -> bank 1), driving the shared compute unit and the
// single result-RAM write port.
// Optional feature: define FAST9_SCHED_WATCHDOG_EN to enable a watchdog that
// aborts a frame when the compute unit stalls for TIMEOUT cycles.
module fast9_frame_scheduler #(
  parameter int WIDTH   = 160,
  parameter int HEIGHT  = 120,
  parameter int BORDER  = 3,
  parameter int ADDR_W  = 15,
  parameter int TIMEOUT = 1023
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              unitReq,
  output logic              unitMode,
  output logic [ADDR_W-1:0] unitAddr,
  input  logic              unitAck,
  input  logic              unitDone,
  input  logic [7:0]        unitResult,
  output logic              outWrite,
  output logic              outBank,
  output logic [ADDR_W-1:0] outAddr,
  output logic [7:0]        outPixel,
  output logic              error
);

  // With no interior pixels there is nothing to scan; the frame ends after CLEAR.
  localparam bit DEGEN = (WIDTH <= 2 * BORDER) || (HEIGHT <= 2 * BORDER);

  localparam logic [ADDR_W-1:0] PIX_LAST   = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [ADDR_W-1:0] POS_FIRST  = ADDR_W'(BORDER);
  localparam logic [ADDR_W-1:0] X_LAST     = DEGEN ? POS_FIRST : ADDR_W'(WIDTH - BORDER - 1);
  localparam logic [ADDR_W-1:0] Y_LAST     = DEGEN ? POS_FIRST : ADDR_W'(HEIGHT - BORDER - 1);
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BORDER * WIDTH + BORDER);
  // Jump from the last interior pixel of a row to the first of the next row.
  localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(2 * BORDER + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, REQ, WAIT, WRITE, FIN} stateT;

  stateT             stateReg, stateNext;
  logic              modeReg, modeNext;
  logic [ADDR_W-1:0] xReg, xNext;
  logic [ADDR_W-1:0] yReg, yNext;
  logic [ADDR_W-1:0] centreReg, centreNext;
  logic [ADDR_W-1:0] clearAddrReg, clearAddrNext;
  logic              clearBankReg, clearBankNext;
  logic [7:0]        resultReg, resultNext;
  // Last write-port values, so the port holds steady between writes.
  logic [ADDR_W-1:0] heldAddrReg;
  logic              heldBankReg;
  logic [7:0]        heldPixelReg;
  logic              timeoutHit;

  assign unitMode = modeReg;
  assign unitAddr = centreReg;

`ifdef FAST9_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wdCountReg;
  logic            errorReg;

  assign timeoutHit = ((stateReg == REQ) || (stateReg == WAIT)) &&
                      (wdCountReg == WD_W'(TIMEOUT));
  assign error = errorReg;

  // Stall counter: restarts on every state change, counts only while waiting on the unit.
  always_ff @(posedge clock) begin
    if (reset || (stateNext != stateReg)) begin
      wdCountReg <= '0;
    end else if ((stateReg == REQ || stateReg == WAIT) && !timeoutHit) begin
      wdCountReg <= wdCountReg + WD_W'(1);
    end
  end

  // Sticky abort flag, cleared by the next accepted start.
  always_ff @(posedge clock) begin
    if (reset) begin
      errorReg <= 1'b0;
    end else if (stateReg == IDLE && start) begin
      errorReg <= 1'b0;
    end else if (timeoutHit) begin
      errorReg <= 1'b1;
    end
  end
`else
  assign timeoutHit = 1'b0;
  assign error      = 1'b0;
`endif

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      stateReg     <= IDLE;
      modeReg      <= 1'b0;
      xReg         <= '0;
      yReg         <= '0;
      centreReg    <= '0;
      clearAddrReg <= '0;
      clearBankReg <= 1'b0;
      resultReg    <= '0;
      heldAddrReg  <= '0;
      heldBankReg  <= 1'b0;
      heldPixelReg <= '0;
    end else begin
      stateReg     <= stateNext;
      modeReg      <= modeNext;
      xReg         <= xNext;
      yReg         <= yNext;
      centreReg    <= centreNext;
      clearAddrReg <= clearAddrNext;
      clearBankReg <= clearBankNext;
      resultReg    <= resultNext;
      heldAddrReg  <= outAddr;
      heldBankReg  <= outBank;
      heldPixelReg <= outPixel;
    end
  end

  // Next-state, scan bookkeeping and output decode.
  always_comb begin
    stateNext     = stateReg;
    modeNext      = modeReg;
    xNext         = xReg;
    yNext         = yReg;
    centreNext    = centreReg;
    clearAddrNext = clearAddrReg;
    clearBankNext = clearBankReg;
    resultNext    = resultReg;
    busy          = 1'b0;
    done          = 1'b0;
    unitReq       = 1'b0;
    outWrite      = 1'b0;
    outAddr       = heldAddrReg;
    outBank       = heldBankReg;
    outPixel      = heldPixelReg;

    case (stateReg)
      IDLE: begin
        if (start) begin
          stateNext     = CLEAR;
          clearAddrNext = '0;
          clearBankNext = 1'b0;
        end
      end

      CLEAR: begin
        busy     = 1'b1;
        outWrite = 1'b1;
        outAddr  = clearAddrReg;
        outBank  = clearBankReg;
        outPixel = 8'h00;
        if (clearAddrReg == PIX_LAST) begin
          clearAddrNext = '0;
          if (clearBankReg) begin
            stateNext  = DEGEN ? FIN : REQ;
            modeNext   = 1'b0;
            xNext      = POS_FIRST;
            yNext      = POS_FIRST;
            centreNext = FIRST_ADDR;
          end else begin
            clearBankNext = 1'b1;
          end
        end else begin
          clearAddrNext = clearAddrReg + ADDR_W'(1);
        end
      end

      REQ: begin
        busy = 1'b1;
        if (timeoutHit) begin
          stateNext = FIN;
        end else begin
          unitReq = 1'b1;
          if (unitAck) begin
            if (unitDone) begin
              resultNext = unitResult;
              stateNext  = WRITE;
            end else begin
              stateNext = WAIT;
            end
          end
        end
      end

      WAIT: begin
        busy = 1'b1;
        if (timeoutHit) begin
          stateNext = FIN;
        end else if (unitDone) begin
          resultNext = unitResult;
          stateNext  = WRITE;
        end
      end

      WRITE: begin
        busy     = 1'b1;
        outWrite = 1'b1;
        outAddr  = centreReg;
        outBank  = modeReg;
        outPixel = modeReg ? ((resultReg != 8'h00) ? 8'hff : 8'h00) : resultReg;
        stateNext = REQ;
        if (xReg == X_LAST) begin
          if (yReg == Y_LAST) begin
            xNext      = POS_FIRST;
            yNext      = POS_FIRST;
            centreNext = FIRST_ADDR;
            if (modeReg) begin
              stateNext = FIN;
            end else begin
              modeNext = 1'b1;
            end
          end else begin
            xNext      = POS_FIRST;
            yNext      = yReg + ADDR_W'(1);
            centreNext = centreReg + ROW_STEP;
          end
        end else begin
          xNext      = xReg + ADDR_W'(1);
          centreNext = centreReg + ADDR_W'(1);
        end
      end

      FIN: begin
        done      = 1'b1;
        stateNext = IDLE;
      end

      default: stateNext = IDLE;
    endcase
  end

endmodule
